// File: rtl/frog_collision_monitor.sv
`default_nettype none
// ============================================================================
// Module      : frog_collision_monitor
// Description : Per-pixel player/car overlap counter with per-frame hit, win,
//               respawn and game-over decisions. Optional macro
//               COLLISION_DEBUG_EN builds the overlap_cnt capture register.
// Revision    : 1.0 - initial release
// ============================================================================
module frog_collision_monitor #(
    parameter int H_DISPLAY     = 640,
    parameter int V_DISPLAY     = 480,
    parameter int HIT_THRESHOLD = 4,
    parameter int INVULN_FRAMES = 60,
    parameter int START_LIVES   = 3,
    parameter int WIN_ROW       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] h_count_i,
    input  logic [9:0] v_count_i,
    input  logic       player_px_i,
    input  logic       car_px_i,
    input  logic [9:0] player_y_i,
    input  logic       restart_i,
    output logic       hit_o,
    output logic       win_o,
    output logic       respawn_o,
    output logic [1:0] lives_o,
    output logic [7:0] score_o,
    output logic       game_over_o,
    output logic [7:0] overlap_cnt_o
);

    localparam logic [9:0] C_H_DISP = 10'(H_DISPLAY);
    localparam logic [9:0] C_V_DISP = 10'(V_DISPLAY);
    localparam logic [7:0] C_HIT    = 8'(HIT_THRESHOLD);
    localparam logic [7:0] C_INV    = 8'(INVULN_FRAMES);
    localparam logic [1:0] C_LIVES  = 2'(START_LIVES);
    localparam logic [9:0] C_WIN    = 10'(WIN_ROW);

    typedef enum logic [1:0] {
        S_PLAY      = 2'd0,
        S_RESPAWN   = 2'd1,
        S_GAME_OVER = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] invuln_q, invuln_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic       hit_q, hit_d;
    logic       win_q, win_d;
    logic       respawn_q, respawn_d;

    logic frame_end;
    logic active_px;

    assign frame_end = (h_count_i == 10'd0) && (v_count_i == C_V_DISP);
    assign active_px = (h_count_i < C_H_DISP) && (v_count_i < C_V_DISP);

    always_comb begin
        acc_d     = acc_q;
        state_d   = state_q;
        invuln_d  = invuln_q;
        lives_d   = lives_q;
        score_d   = score_q;
        hit_d     = 1'b0;
        win_d     = 1'b0;
        respawn_d = 1'b0;

        if (frame_end) begin
            acc_d = 8'd0;
        end else if (active_px && player_px_i && car_px_i && (acc_q != 8'hFF)) begin
            acc_d = acc_q + 8'd1;
        end

        if (frame_end) begin
            case (state_q)
                S_PLAY: begin
                    if (acc_q >= C_HIT) begin
                        hit_d     = 1'b1;
                        respawn_d = 1'b1;
                        lives_d   = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_d = S_GAME_OVER;
                        end else begin
                            state_d  = S_RESPAWN;
                            invuln_d = C_INV;
                        end
                    end else if (player_y_i <= C_WIN) begin
                        win_d     = 1'b1;
                        respawn_d = 1'b1;
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
                S_RESPAWN: begin
                    // Treat a zero counter like the last frame so the FSM can never stick.
                    if (invuln_q <= 8'd1) begin
                        invuln_d = 8'd0;
                        state_d  = S_PLAY;
                    end else begin
                        invuln_d = invuln_q - 8'd1;
                    end
                end
                S_GAME_OVER: begin
                    if (restart_i) begin
                        state_d   = S_PLAY;
                        lives_d   = C_LIVES;
                        score_d   = 8'd0;
                        respawn_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_PLAY;
            acc_q     <= 8'd0;
            invuln_q  <= 8'd0;
            lives_q   <= C_LIVES;
            score_q   <= 8'd0;
            hit_q     <= 1'b0;
            win_q     <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            invuln_q  <= invuln_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            hit_q     <= hit_d;
            win_q     <= win_d;
            respawn_q <= respawn_d;
        end
    end

    assign hit_o       = hit_q;
    assign win_o       = win_q;
    assign respawn_o   = respawn_q;
    assign lives_o     = lives_q;
    assign score_o     = score_q;
    assign game_over_o = (state_q == S_GAME_OVER);

`ifdef COLLISION_DEBUG_EN
    logic [7:0] overlap_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overlap_q <= 8'd0;
        end else if (frame_end) begin
            overlap_q <= acc_q;
        end
    end

    assign overlap_cnt_o = overlap_q;
`else
    assign overlap_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frog_collision_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_frog_collision_monitor
// Description : Scoreboard bench for frog_collision_monitor on a reduced raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frog_collision_monitor;

    localparam int H_DISP = 32;
    localparam int V_DISP = 12;
    localparam int H_TOT  = 40;
    localparam int V_TOT  = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    logic       player_px = 1'b0;
    logic       car_px = 1'b0;
    logic [9:0] player_y = 10'd100;
    logic       restart = 1'b0;
    logic       hit, win, respawn, game_over;
    logic [1:0] lives;
    logic [7:0] score, overlap_cnt;

    frog_collision_monitor #(
        .H_DISPLAY(H_DISP), .V_DISPLAY(V_DISP), .HIT_THRESHOLD(4),
        .INVULN_FRAMES(2), .START_LIVES(3), .WIN_ROW(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .h_count_i(h_count), .v_count_i(v_count),
        .player_px_i(player_px), .car_px_i(car_px), .player_y_i(player_y),
        .restart_i(restart), .hit_o(hit), .win_o(win), .respawn_o(respawn),
        .lives_o(lives), .score_o(score), .game_over_o(game_over),
        .overlap_cnt_o(overlap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int hit, win, resp, go, lives, score, ovl;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int id, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL frame%0d %s: got %0d expected %0d", id, name, got, exp);
        end
    endtask

    function automatic int dbg(input int v);
`ifdef COLLISION_DEBUG_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // rmode: 0 restart low, 1 restart high all frame, 2 high except on the frame-end cycle
    task automatic run_frame(input int id, input int n_ovl, input int py, input int rmode,
                             input int rst_at, input int e_hit, input int e_win,
                             input int e_resp, input int e_lives, input int e_score,
                             input int e_go, input int e_ovl);
        exp_t e;
        int   idx = 0;
        int   cyc = 0;
        logic act, fe;
        e.id = id; e.hit = e_hit; e.win = e_win; e.resp = e_resp; e.go = e_go;
        e.lives = e_lives; e.score = e_score; e.ovl = dbg(e_ovl);
        q.push_back(e);
        player_y = 10'(py);
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                @(posedge clk);
                #1;
                if (rst_at >= 0 && cyc == rst_at + 1) begin
                    chk("rst_hit", id, int'(hit), 0);
                    chk("rst_win", id, int'(win), 0);
                    chk("rst_respawn", id, int'(respawn), 0);
                    chk("rst_game_over", id, int'(game_over), 0);
                    chk("rst_lives", id, int'(lives), 3);
                    chk("rst_score", id, int'(score), 0);
                    chk("rst_overlap", id, int'(overlap_cnt), 0);
                end
                act       = (h < H_DISP) && (v < V_DISP);
                fe        = (h == 0) && (v == V_DISP);
                h_count   = 10'(h);
                v_count   = 10'(v);
                car_px    = act && (idx < n_ovl);
                player_px = act && (idx < n_ovl + 3);
                restart   = (rmode == 1) || (rmode == 2 && !fe);
                rst       = (cyc == rst_at);
                if (act) idx++;
                cyc++;
            end
        end
    endtask

    initial begin : monitor
        logic fe_prev  = 1'b0;
        logic pulse_ck = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (pulse_ck) begin
                chk("hit_width", e.id, int'(hit), 0);
                chk("win_width", e.id, int'(win), 0);
                chk("respawn_width", e.id, int'(respawn), 0);
            end
            pulse_ck = 1'b0;
            if (fe_prev) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL scoreboard: frame end with no expectation queued");
                end else begin
                    e = q.pop_front();
                    chk("hit", e.id, int'(hit), e.hit);
                    chk("win", e.id, int'(win), e.win);
                    chk("respawn", e.id, int'(respawn), e.resp);
                    chk("lives", e.id, int'(lives), e.lives);
                    chk("score", e.id, int'(score), e.score);
                    chk("game_over", e.id, int'(game_over), e.go);
                    chk("overlap_cnt", e.id, int'(overlap_cnt), e.ovl);
                    pulse_ck = 1'b1;
                end
            end
            fe_prev = !rst && (h_count == 10'd0) && (v_count == 10'(V_DISP));
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lives", 0, int'(lives), 3);
        chk("reset_score", 0, int'(score), 0);
        chk("reset_hit", 0, int'(hit), 0);
        chk("reset_win", 0, int'(win), 0);
        chk("reset_respawn", 0, int'(respawn), 0);
        chk("reset_game_over", 0, int'(game_over), 0);
        chk("reset_overlap", 0, int'(overlap_cnt), 0);
        rst = 1'b0;
        //        id ovl  py  rm  rst  hit win rsp lv sc go ovl
        run_frame( 1,   3, 100, 0,  -1,  0,  0,  0, 3, 0, 0,   3);
        run_frame( 2,   2, 100, 0,  -1,  0,  0,  0, 3, 0, 0,   2);
        run_frame( 3,   2, 100, 0,  -1,  0,  0,  0, 3, 0, 0,   2);
        run_frame( 4,   0,  10, 0,  -1,  0,  1,  1, 3, 1, 0,   0);
        run_frame( 5,   6,  10, 0,  -1,  1,  0,  1, 2, 1, 0,   6);
        run_frame( 6,   5,  10, 0,  -1,  0,  0,  0, 2, 1, 0,   5);
        run_frame( 7,   5, 100, 0,  -1,  0,  0,  0, 2, 1, 0,   5);
        run_frame( 8,   5, 100, 0,  -1,  1,  0,  1, 1, 1, 0,   5);
        run_frame( 9,   0, 100, 0,  -1,  0,  0,  0, 1, 1, 0,   0);
        run_frame(10,   0, 100, 0,  -1,  0,  0,  0, 1, 1, 0,   0);
        run_frame(11,   4, 100, 0,  -1,  1,  0,  1, 0, 1, 1,   4);
        run_frame(12,   4,  10, 2,  -1,  0,  0,  0, 0, 1, 1,   4);
        run_frame(13,   0, 100, 1,  -1,  0,  0,  1, 3, 0, 0,   0);
        run_frame(14, 300, 100, 0,  -1,  1,  0,  1, 2, 0, 0, 255);
        run_frame(15,   7, 100, 0,  -1,  0,  0,  0, 2, 0, 0,   7);
        run_frame(16,   0, 100, 0,  -1,  0,  0,  0, 2, 0, 0,   0);
        run_frame(17,  10, 100, 0, 100,  0,  0,  0, 3, 0, 0,   0);
        run_frame(18,   0,  16, 0,  -1,  0,  1,  1, 3, 1, 0,   0);
        run_frame(19,   0,  17, 0,  -1,  0,  0,  0, 3, 1, 0,   0);
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 99, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
